// File: rtl/pipe_shifter.sv
// pipe_shifter: two-stage valid/ready shift/rotate unit.
// Stage 1 captures the request. A log-depth right-shift network then runs
// between stage 1 and the output stage. Left operations reuse that network
// by bit-reversing the operand before and after it.
module pipe_shifter #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   amount,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             busy
);

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;
  localparam logic [2:0] MODE_LUI = 3'd5;

  // Stage 1: captured request
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [SHW-1:0]   s1_amt_q,   s1_amt_d;
  logic [2:0]       s1_mode_q,  s1_mode_d;

  // Stage 2: registered result, with its zero flag held alongside
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_zero_q,  s2_zero_d;

  logic s2_free;
  logic s1_adv;
  logic accept;

  // The output stage can take a new entry when it is empty or is being
  // drained this cycle. Stage 1 follows the same rule one step upstream.
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  // Shift network datapath
  logic                     left_op;
  logic                     rot_op;
  logic                     fill_bit;
  logic [WIDTH-1:0]         rev_in;
  logic [WIDTH-1:0]         rev_out;
  logic [SHW:0][WIDTH-1:0]  lvl;
  logic [WIDTH-1:0]         result;

  // Decode which flavour of right shift the shared network performs
  always_comb begin
    left_op  = (s1_mode_q == MODE_SLL) || (s1_mode_q == MODE_ROL);
    rot_op   = (s1_mode_q == MODE_ROL) || (s1_mode_q == MODE_ROR);
    fill_bit = (s1_mode_q == MODE_SRA) ? s1_data_q[WIDTH-1] : 1'b0;
  end

  // Reverse the operand so that left shifts become right shifts
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev_in
    assign rev_in[gi] = s1_data_q[WIDTH-1-gi];
  end

  assign lvl[0] = left_op ? rev_in : s1_data_q;

  // Each level shifts right by 2**gi. Vacated bits come from the low end
  // when rotating, or from the fill bit when shifting.
  for (genvar gi = 0; gi < SHW; gi++) begin : g_level
    localparam int S = 2 ** gi;
    logic [WIDTH-1:0] shifted;
    assign shifted    = {(rot_op ? lvl[gi][S-1:0] : {S{fill_bit}}), lvl[gi][WIDTH-1:S]};
    assign lvl[gi+1]  = s1_amt_q[gi] ? shifted : lvl[gi];
  end

  // Undo the reversal for left operations
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev_out
    assign rev_out[gi] = lvl[SHW][WIDTH-1-gi];
  end

  // Select the final result for the operation held in stage 1
  always_comb begin
    result = s1_data_q;
    case (s1_mode_q)
      MODE_SLL, MODE_ROL:           result = rev_out;
      MODE_SRL, MODE_SRA, MODE_ROR: result = lvl[SHW];
      MODE_LUI:                     result = {s1_data_q[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:                      result = s1_data_q;
    endcase
  end

  // Next-state for both pipeline stages
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_amt_d   = s1_amt_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_zero_d  = s2_zero_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_amt_d   = amount;
      s1_mode_d  = mode;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = result;
      s2_zero_d  = (result == '0);
    end else if (s2_valid_q && out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset empties both stages immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_amt_q   <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_zero_q  <= 1'b1;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_amt_q   <= s1_amt_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_zero  = s2_zero_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: scoreboard bench for pipe_shifter (WIDTH=16).
// Stimulus pushes hand-computed expectations at accept time. A separate
// monitor pops one expectation on every output handshake and compares.
module tb_pipe_shifter;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   amount;
  logic [2:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             busy;

  pipe_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .amount    (amount),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   rnd_rdy = 1'b0;
  logic rdy_forced = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: forced level or random stalls
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_forced;
    end
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Bitwise reference for the randomized run
  function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] a, input logic [2:0] m);
    logic [15:0] r;
    int k;
    k = int'(a);
    r = '0;
    for (int i = 0; i < 16; i++) begin
      case (m)
        3'd0:    r[i] = (i >= k) ? d[(i - k) % 16] : 1'b0;
        3'd1:    r[i] = (i + k < 16) ? d[(i + k) % 16] : 1'b0;
        3'd2:    r[i] = (i + k < 16) ? d[(i + k) % 16] : d[15];
        3'd3:    r[i] = d[(i - k + 16) % 16];
        3'd4:    r[i] = d[(i + k) % 16];
        3'd5:    r[i] = (i >= 8) ? d[i - 8] : 1'b0;
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Issue one request; push its expectation when it is accepted
  task automatic send(input logic [15:0] d, input logic [3:0] a, input logic [2:0] m,
                      input logic [15:0] e, input bit lat);
    exp_t x;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    amount   = a;
    mode     = m;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        x.data    = e;
        x.zero    = (e == 16'h0000);
        x.acc_cyc = cyc;
        x.chk_lat = lat;
        sb.push_back(x);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: request not accepted in 200 cycles, expected accept");
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    amount   = 4'($urandom);
    mode     = 3'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares on handshakes and checks hold stability while stalled
  initial begin
    exp_t        x;
    bit          held;
    logic [15:0] hd;
    logic        hz;
    held = 1'b0;
    hd   = '0;
    hz   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          if (held) begin
            chk16("stall_hold_data", out_data, hd);
            chk1("stall_hold_zero", out_zero, hz);
          end
          held = 1'b1;
          hd   = out_data;
          hz   = out_zero;
        end else begin
          held = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h with empty scoreboard, expected no output", out_data);
          end else begin
            x = sb.pop_front();
            $display("result %h zero %b (expected %h)", out_data, out_zero, x.data);
            chk16("out_data", out_data, x.data);
            chk1("out_zero", out_zero, x.zero);
            if (x.chk_lat) begin
              checks++;
              if (cyc - x.acc_cyc != 2) begin
                errors++;
                $display("FAIL latency: got %0d cycles, expected 2", cyc - x.acc_cyc);
              end
            end
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t        x;
    logic [15:0] d;
    logic [3:0]  a;
    logic [2:0]  m;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    amount   = '0;
    mode     = '0;
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_zero", out_zero, 1'b1);
    chk16("rst_out_data", out_data, 16'h0000);

    // First rising edge after release accepts a request
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    amount   = 4'd5;
    mode     = 3'd6;
    #1;
    chk1("first_edge_in_ready", in_ready, 1'b1);
    x.data = 16'h1234; x.zero = 1'b0; x.acc_cyc = cyc; x.chk_lat = 1'b1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk1("first_edge_busy", busy, 1'b1);

    // Back-to-back shifts and rotates
    send(16'h8001, 4'd3, 3'd0, 16'h0008, 1'b1);
    send(16'h8001, 4'd3, 3'd1, 16'h1000, 1'b1);
    send(16'h8001, 4'd3, 3'd2, 16'hF000, 1'b1);
    send(16'h8001, 4'd3, 3'd3, 16'h000C, 1'b1);
    send(16'h8001, 4'd3, 3'd4, 16'h3000, 1'b1);
    // LUI ignores amount
    send(16'h8001, 4'd7,     3'd5, 16'h0100, 1'b1);
    send(16'h8001, 4'd9,     3'd5, 16'h0100, 1'b1);
    send(16'h8001, 4'(21),   3'd5, 16'h0100, 1'b1);
    // Boundary amounts, zero result, pass modes
    send(16'h8001, 4'd0,  3'd3, 16'h8001, 1'b1);
    send(16'h8001, 4'd0,  3'd2, 16'h8001, 1'b1);
    send(16'h0001, 4'd1,  3'd1, 16'h0000, 1'b1);
    send(16'h8000, 4'd15, 3'd2, 16'hFFFF, 1'b1);
    send(16'h7FFF, 4'd4,  3'd2, 16'h07FF, 1'b1);
    send(16'h0003, 4'd15, 3'd0, 16'h8000, 1'b1);
    send(16'h8001, 4'd15, 3'd4, 16'h0003, 1'b1);
    send(16'hA5C3, 4'd5,  3'd6, 16'hA5C3, 1'b1);
    send(16'h5A3C, 4'd9,  3'd7, 16'h5A3C, 1'b1);
    drain();

    // Stall: two accepts fill the pipe, third waits for release
    rdy_forced = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(16'h00F0, 4'd4, 3'd0, 16'h0F00, 1'b0);
    send(16'h1234, 4'd4, 3'd4, 16'h4123, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("stall_in_ready", in_ready, 1'b0);
      chk1("stall_out_valid", out_valid, 1'b1);
      chk16("stall_out_data", out_data, 16'h0F00);
    end
    @(posedge clk);
    #1;
    fork
      send(16'h8421, 4'd2, 3'd2, 16'hE108, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #2;
        rdy_forced = 1'b1;
      end
    join
    drain();

    // Reset with two entries in flight
    rdy_forced = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(16'hABCD, 4'd0, 3'd6, 16'hABCD, 1'b0);
    send(16'h1111, 4'd0, 3'd6, 16'h1111, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_out_zero", out_zero, 1'b1);
    chk16("midrst_out_data", out_data, 16'h0000);
    sb.delete();
    @(negedge clk);
    reset      = 1'b0;
    rdy_forced = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("post_rst_out_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Randomized run with random output stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      d = 16'($urandom);
      a = 4'($urandom);
      m = 3'($urandom_range(0, 7));
      send(d, a, m, model(d, a, m), 1'b0);
    end
    drain();
    rnd_rdy = 1'b0;
    chk1("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
